// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file write-port controller.
//   DATA_WIDTH / ADDR_WIDTH : default widths for the 32x32 register file
//   NUM_REGS                : register count implied by ADDR_WIDTH
//   state_t                 : controller state encoding
//   wreq_t                  : write request record (valid, addr, data)
package rf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wreq_t;

endpackage

// File: rtl/rf_wport_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : request lines (already qualified by the caller)
//   fire     : a transfer to the current grant happened this cycle
//   gnt[1:0] : one-hot grant, combinational from req and the priority bit
// The priority bit points at the requester that wins a tie; after a fire it
// moves to the requester that did not fire.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       fire,
    output logic [1:0] gnt
);

    logic prio;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Fire to req0 hands the tie to req1 and vice versa.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (fire) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/rf_wport_ctrl.sv
// rf_wport_ctrl: write-port controller for the general-purpose register file.
// After reset it sweeps zeros into registers 1..NUM_REGS-1, then arbitrates
// the single write port between two valid/ready requesters.
//   clk, rst                        : clock, synchronous active-high reset
//   req0_valid/addr/data, req0_ready: ALU writeback requester
//   req1_valid/addr/data, req1_ready: load writeback requester
//   rf_wen, rf_waddr, rf_wdata      : registered register-file write port
//   init_done                       : zero sweep finished, arbitration live
//   zero_drop                       : pulse, accepted write to r0 discarded
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | zero sweep, one register per cycle from cnt=1, readies low
// ARB   | round-robin arbitration, one write per fire
module rf_wport_ctrl
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  init_done,
    output logic                  zero_drop
);

    localparam int CNT_W     = ADDR_WIDTH + 1;
    localparam int NREGS     = 2 ** ADDR_WIDTH;
    // One extra counter bit keeps the last-address compare from wrapping.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NREGS - 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            req_vec;
    logic [1:0]            gnt;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Requests are masked outside ARB and during reset so no ready can rise.
    assign req_vec = {req1_valid, req0_valid} & {2{(state == ARB) && !rst}};

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req_vec),
        .fire (fire),
        .gnt  (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    // A grant is only ever given to a valid requester, so any grant is a fire.
    assign fire       = |gnt;
    assign sel_addr   = gnt[1] ? req1_addr : req0_addr;
    assign sel_data   = gnt[1] ? req1_data : req0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= CNT_W'(1);
            rf_wen    <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            init_done <= 1'b0;
            zero_drop <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    rf_wen    <= 1'b1;
                    rf_waddr  <= cnt[ADDR_WIDTH-1:0];
                    rf_wdata  <= '0;
                    zero_drop <= 1'b0;
                    cnt       <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state     <= ARB;
                        init_done <= 1'b1;
                    end
                end
                ARB: begin
                    rf_wen    <= 1'b0;
                    zero_drop <= 1'b0;
                    if (fire) begin
                        rf_waddr  <= sel_addr;
                        rf_wdata  <= sel_data;
                        // r0 is hardwired zero: complete the handshake, drop the write.
                        rf_wen    <= (sel_addr != '0);
                        zero_drop <= (sel_addr == '0);
                    end
                end
                default: begin
                    state <= INIT;
                    cnt   <= CNT_W'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wport_ctrl.sv
// tb_rf_wport_ctrl: directed self-checking bench for rf_wport_ctrl.
// A small register-file model (r0 cleared by reset only) follows the write port.
module tb_rf_wport_ctrl;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;
    logic        zero_drop;

    logic [31:0] mem [32];

    int checks;
    int errors;

    rf_wport_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .init_done  (init_done),
        .zero_drop  (zero_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            mem[0] <= 32'h0;
        end else if (rf_wen && rf_waddr != 5'd0) begin
            mem[rf_waddr] <= rf_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h1234;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h5678;
        step();
        step();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got=%0b exp=0", rf_wen); end
        checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
        checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got=%0b exp=0", init_done); end
        checks++; if (zero_drop !== 1'b0) begin errors++; $display("FAIL reset_zero_drop got=%0b exp=0", zero_drop); end
        checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {req1_ready, req0_ready}); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    // Expects rst just released; checks edges 1..31 of the sweep.
    task automatic test_sweep(input string tag);
        for (int k = 1; k <= 31; k++) begin
            step();
            checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL %s_wen k=%0d got=%0b exp=1", tag, k, rf_wen); end
            checks++; if (rf_waddr !== 5'(k)) begin errors++; $display("FAIL %s_waddr got=%0d exp=%0d", tag, rf_waddr, k); end
            checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL %s_wdata k=%0d got=%h exp=0", tag, k, rf_wdata); end
            checks++; if (init_done !== (k == 31)) begin errors++; $display("FAIL %s_init_done k=%0d got=%0b exp=%0b", tag, k, init_done, k == 31); end
            if (k < 31) begin
                req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'hBAD0;
                req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'hBAD1;
                #1;
                checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL %s_ready k=%0d got=%b exp=00", tag, k, {req1_ready, req0_ready}); end
            end else begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", {req1_ready, req0_ready}); end
        step();
        req0_valid = 1'b0;
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL single_wen got=%0b exp=1", rf_wen); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL single_waddr got=%0d exp=5", rf_waddr); end
        checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata got=%h exp=deadbeef", rf_wdata); end
        step();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL single_idle_wen got=%0b exp=0", rf_wen); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL single_hold_waddr got=%0d exp=5", rf_waddr); end
        checks++; if (mem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_commit got=%h exp=deadbeef", mem[5]); end
    endtask

    // Runs with prio=1 after test_single: req1 wins, and it targets r0.
    task automatic test_zero();
        req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hC0C0;
        req1_valid = 1'b1; req1_addr = 5'd0;  req1_data = 32'hFFFF;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL zero_ready got=%b exp=10", {req1_ready, req0_ready}); end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL zero_wen got=%0b exp=0", rf_wen); end
        checks++; if (zero_drop !== 1'b1) begin errors++; $display("FAIL zero_drop got=%0b exp=1", zero_drop); end
        step();
        checks++; if (zero_drop !== 1'b0) begin errors++; $display("FAIL zero_drop_pulse got=%0b exp=0", zero_drop); end
        checks++; if (mem[0] !== 32'h0) begin errors++; $display("FAIL zero_r0 got=%h exp=0", mem[0]); end
    endtask

    // prio=0 here: grants alternate req0, req1, req0, req1.
    task automatic test_back_to_back();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL b2b_ready i=%0d got=%b exp=%b", i, {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10); end
            step();
            checks++; if (rf_waddr !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin errors++; $display("FAIL b2b_waddr i=%0d got=%0d exp=%0d", i, rf_waddr, (i % 2 == 0) ? 3 : 4); end
            checks++; if (rf_wdata !== ((i % 2 == 0) ? 32'h11 : 32'h22)) begin errors++; $display("FAIL b2b_wdata i=%0d got=%h exp=%h", i, rf_wdata, (i % 2 == 0) ? 32'h11 : 32'h22); end
            checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL b2b_wen i=%0d got=%0b exp=1", i, rf_wen); end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        checks++; if (mem[3] !== 32'h11) begin errors++; $display("FAIL b2b_r3 got=%h exp=11", mem[3]); end
        checks++; if (mem[4] !== 32'h22) begin errors++; $display("FAIL b2b_r4 got=%h exp=22", mem[4]); end
    endtask

    // Same register from both requesters back to back, then req0 waits while req1 is granted.
    task automatic test_prio_hold();
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        #1;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hAA;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL same_reg_ready got=%b exp=10", {req1_ready, req0_ready}); end
        step();
        req1_valid = 1'b0;
        step();
        checks++; if (mem[9] !== 32'hAA) begin errors++; $display("FAIL same_reg_order got=%h exp=aa", mem[9]); end
        // prio=0 now; fire req0 once so req1 holds the tie.
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
        #1;
        step();
        req0_addr = 5'd7; req0_data = 32'hA5A5;
        req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h5A5A;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL hold_req0_ready got=%0b exp=0", req0_ready); end
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL hold_req1_ready got=%0b exp=1", req1_ready); end
        step();
        req1_valid = 1'b0;
        checks++; if (rf_waddr !== 5'd8 || rf_wdata !== 32'h5A5A) begin errors++; $display("FAIL hold_first got=%0d/%h exp=8/5a5a", rf_waddr, rf_wdata); end
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL hold_req0_later got=%0b exp=1", req0_ready); end
        step();
        req0_valid = 1'b0;
        checks++; if (rf_waddr !== 5'd7 || rf_wdata !== 32'hA5A5 || rf_wen !== 1'b1) begin errors++; $display("FAIL hold_second got=%0d/%h/%0b exp=7/a5a5/1", rf_waddr, rf_wdata, rf_wen); end
    endtask

    task automatic test_reset_in_arb();
        step();
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66;
        rst = 1'b1;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL arb_rst_ready got=%b exp=00", {req1_ready, req0_ready}); end
        step();
        checks++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin errors++; $display("FAIL arb_rst_write got=%0b/%0d/%h exp=0/0/0", rf_wen, rf_waddr, rf_wdata); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL arb_rst_init_done got=%0b exp=0", init_done); end
        checks++; if (mem[6] === 32'h66) begin errors++; $display("FAIL arb_rst_commit got=%h exp=not 66", mem[6]); end
        req0_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        for (int k = 1; k <= 17; k++) step();
        checks++; if (rf_waddr !== 5'd17 || rf_wen !== 1'b1) begin errors++; $display("FAIL mid_sweep_addr got=%0d/%0b exp=17/1", rf_waddr, rf_wen); end
        rst = 1'b1;
        step();
        checks++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd0) begin errors++; $display("FAIL mid_sweep_rst got=%0b/%0d exp=0/0", rf_wen, rf_waddr); end
        rst = 1'b0;
        test_sweep("resweep");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        test_reset();
        test_sweep("sweep");
        test_single();
        test_zero();
        test_back_to_back();
        test_prio_hold();
        test_reset_in_arb();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
